// File: rtl/idli_pkg.sv
// Shared types for the idli core slice used by the UART block.
// - sqi_data_t   : nibble carried on the EX nibble-serial ports
// - uart_byte_t  : one UART character
// - uart_state_t : frame phase shared by the TX and RX state machines
// - UART_ERR_*   : bit positions inside the sticky UART error vector
package idli_pkg;

   typedef logic [3:0] sqi_data_t;
   typedef logic [7:0] uart_byte_t;

   typedef enum logic [1:0] {
      UART_STATE_IDLE,
      UART_STATE_START,
      UART_STATE_DATA,
      UART_STATE_STOP
   } uart_state_t;

   localparam int UART_ERR_TX_OVF = 0;
   localparam int UART_ERR_RX_OVF = 1;
   localparam int UART_ERR_RX_FRM = 2;

endpackage

// File: rtl/idli_uart_fifo_m.sv
// Small synchronous FIFO used for the UART TX and RX byte queues.
// Ports:
// - clk, rst        : clock, asynchronous active-high reset
// - push, push_data : write request and data; ignored when full unless a pop
//                     happens in the same cycle
// - pop             : remove the head entry; ignored when empty
// - full, empty     : occupancy flags
// - head            : oldest entry, visible combinationally
module idli_uart_fifo_m #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A pop frees the slot being written, so a push into a full FIFO is
   // still honoured when it coincides with a pop.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/idli_uart_m.sv
// 8N1 byte UART behind the EX unit's nibble-serial UART port.
// Ports:
// - i_uart_gck, i_uart_rst : clock, asynchronous active-high reset
// - i_uart_tx_vld/_data    : TX nibbles from EX, low nibble of each byte first
// - o_uart_rx_data         : front RX nibble (0 when the RX FIFO is empty)
// - i_uart_rx_acp          : EX consumes o_uart_rx_data this cycle
// - i_uart_rx_pin          : asynchronous serial input, idle high
// - o_uart_tx_pin          : serial output, idle high
// - o_uart_tx_full         : TX FIFO full
// - o_uart_rx_empty        : RX FIFO empty
// - o_uart_err             : sticky {rx_framing, rx_overflow, tx_overflow}
module idli_uart_m
   import idli_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic      i_uart_gck,
   input  logic      i_uart_rst,
   input  logic      i_uart_tx_vld,
   input  sqi_data_t i_uart_tx_data,
   output sqi_data_t o_uart_rx_data,
   input  logic      i_uart_rx_acp,
   input  logic      i_uart_rx_pin,
   output logic      o_uart_tx_pin,
   output logic      o_uart_tx_full,
   output logic      o_uart_rx_empty,
   output logic [2:0] o_uart_err
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

   // ---------------- TX nibble packer and FIFO ----------------
   logic       tx_nib_ptr_reg;
   sqi_data_t  tx_lo_reg;
   logic       tx_push;
   uart_byte_t tx_push_byte;
   logic       tx_pop;
   logic       tx_full;
   logic       tx_empty;
   uart_byte_t tx_head;

   assign tx_push      = i_uart_tx_vld & tx_nib_ptr_reg;
   assign tx_push_byte = {i_uart_tx_data, tx_lo_reg};

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         tx_nib_ptr_reg <= 1'b0;
         tx_lo_reg      <= '0;
      end else if (i_uart_tx_vld) begin
         if (!tx_nib_ptr_reg) tx_lo_reg <= i_uart_tx_data;
         tx_nib_ptr_reg <= ~tx_nib_ptr_reg;
      end
   end

   idli_uart_fifo_m #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (i_uart_gck),
      .rst       (i_uart_rst),
      .push      (tx_push),
      .push_data (tx_push_byte),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (tx_head)
   );

   // ---------------- TX serialiser ----------------
   uart_state_t      tx_state_reg, tx_state_next;
   logic [DIV_W-1:0] tx_div_reg, tx_div_next;
   logic [2:0]       tx_bit_reg, tx_bit_next;
   uart_byte_t       tx_shift_reg, tx_shift_next;
   logic             tx_pin_reg, tx_pin_next;
   logic             tx_div_end;

   assign tx_div_end = (tx_div_reg == DIV_LAST);

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         tx_state_reg <= UART_STATE_IDLE;
         tx_div_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_pin_reg   <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_div_reg   <= tx_div_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         tx_pin_reg   <= tx_pin_next;
      end
   end

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_div_next   = tx_div_end ? '0 : tx_div_reg + 1'b1;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_pop        = 1'b0;
      case (tx_state_reg)
         UART_STATE_IDLE: begin
            tx_div_next = '0;
            if (!tx_empty) begin
               tx_pop        = 1'b1;
               tx_shift_next = tx_head;
               tx_state_next = UART_STATE_START;
            end
         end
         UART_STATE_START: begin
            if (tx_div_end) begin
               tx_bit_next   = '0;
               tx_state_next = UART_STATE_DATA;
            end
         end
         UART_STATE_DATA: begin
            if (tx_div_end) begin
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               tx_bit_next   = tx_bit_reg + 3'd1;
               if (tx_bit_reg == 3'd7) tx_state_next = UART_STATE_STOP;
            end
         end
         UART_STATE_STOP: begin
            if (tx_div_end) tx_state_next = UART_STATE_IDLE;
         end
         default: tx_state_next = UART_STATE_IDLE;
      endcase
      // Pin is registered from the next state so it changes cleanly on the edge.
      case (tx_state_next)
         UART_STATE_START: tx_pin_next = 1'b0;
         UART_STATE_DATA:  tx_pin_next = tx_shift_next[0];
         default:          tx_pin_next = 1'b1;
      endcase
   end

   assign o_uart_tx_pin  = tx_pin_reg;
   assign o_uart_tx_full = tx_full;

   // ---------------- RX synchroniser and deserialiser ----------------
   logic rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
   logic rx_fall;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         rx_sync1_reg <= 1'b1;
         rx_sync2_reg <= 1'b1;
         rx_prev_reg  <= 1'b1;
      end else begin
         rx_sync1_reg <= i_uart_rx_pin;
         rx_sync2_reg <= rx_sync1_reg;
         rx_prev_reg  <= rx_sync2_reg;
      end
   end

   assign rx_fall = rx_prev_reg & ~rx_sync2_reg;

   uart_state_t      rx_state_reg, rx_state_next;
   logic [DIV_W-1:0] rx_div_reg, rx_div_next;
   logic [2:0]       rx_bit_reg, rx_bit_next;
   uart_byte_t       rx_shift_reg, rx_shift_next;
   logic             rx_wait_reg, rx_wait_next;
   logic             rx_push;
   logic             rx_frm;
   logic             rx_div_end;

   assign rx_div_end = (rx_div_reg == DIV_LAST);

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         rx_state_reg <= UART_STATE_IDLE;
         rx_div_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rx_wait_reg  <= 1'b0;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_div_reg   <= rx_div_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         rx_wait_reg  <= rx_wait_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_div_next   = rx_div_end ? '0 : rx_div_reg + 1'b1;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_wait_next  = rx_wait_reg;
      rx_push       = 1'b0;
      rx_frm        = 1'b0;
      case (rx_state_reg)
         UART_STATE_IDLE: begin
            rx_div_next = '0;
            if (rx_fall) rx_state_next = UART_STATE_START;
         end
         UART_STATE_START: begin
            // Half a bit in: later samples then land mid-bit every CLK_DIV.
            if (rx_div_reg == DIV_HALF) begin
               rx_div_next   = '0;
               rx_bit_next   = '0;
               rx_state_next = rx_sync2_reg ? UART_STATE_IDLE : UART_STATE_DATA;
            end
         end
         UART_STATE_DATA: begin
            if (rx_div_end) begin
               rx_shift_next = {rx_sync2_reg, rx_shift_reg[7:1]};
               rx_bit_next   = rx_bit_reg + 3'd1;
               if (rx_bit_reg == 3'd7) rx_state_next = UART_STATE_STOP;
            end
         end
         UART_STATE_STOP: begin
            if (rx_wait_reg) begin
               // After a framing error, hold off until the line is idle again.
               if (rx_sync2_reg) begin
                  rx_wait_next  = 1'b0;
                  rx_state_next = UART_STATE_IDLE;
               end
            end else if (rx_div_end) begin
               if (rx_sync2_reg) begin
                  rx_push       = 1'b1;
                  rx_state_next = UART_STATE_IDLE;
               end else begin
                  rx_frm       = 1'b1;
                  rx_wait_next = 1'b1;
               end
            end
         end
         default: rx_state_next = UART_STATE_IDLE;
      endcase
   end

   // ---------------- RX FIFO and nibble reader ----------------
   logic       rx_nib_ptr_reg;
   logic       rx_pop;
   logic       rx_full;
   logic       rx_empty;
   uart_byte_t rx_head;

   assign rx_pop = i_uart_rx_acp & ~rx_empty & rx_nib_ptr_reg;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         rx_nib_ptr_reg <= 1'b0;
      end else if (i_uart_rx_acp && !rx_empty) begin
         rx_nib_ptr_reg <= ~rx_nib_ptr_reg;
      end
   end

   idli_uart_fifo_m #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (i_uart_gck),
      .rst       (i_uart_rst),
      .push      (rx_push),
      .push_data (rx_shift_reg),
      .pop       (rx_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );

   assign o_uart_rx_data  = rx_empty ? '0 : (rx_nib_ptr_reg ? rx_head[7:4] : rx_head[3:0]);
   assign o_uart_rx_empty = rx_empty;

   // ---------------- Sticky errors ----------------
   logic [2:0] err_reg;

   always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
      if (i_uart_rst) begin
         err_reg <= '0;
      end else begin
         if (tx_push & tx_full & ~tx_pop) err_reg[UART_ERR_TX_OVF] <= 1'b1;
         if (rx_push & rx_full & ~rx_pop) err_reg[UART_ERR_RX_OVF] <= 1'b1;
         if (rx_frm)                      err_reg[UART_ERR_RX_FRM] <= 1'b1;
      end
   end

   assign o_uart_err = err_reg;

endmodule

// File: tb/tb_idli_uart_m.sv
module tb_idli_uart_m;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       tx_vld   = 1'b0;
   logic [3:0] tx_data  = '0;
   logic       rx_acp   = 1'b0;
   logic       rx_line  = 1'b1;
   logic       loopback = 1'b0;
   logic       rx_pin;
   logic [3:0] rx_data;
   logic       tx_pin;
   logic       tx_full;
   logic       rx_empty;
   logic [2:0] err;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [2:0] exp_err      = '0;

   assign rx_pin = loopback ? tx_pin : rx_line;

   idli_uart_m #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .i_uart_gck      (clk),
      .i_uart_rst      (rst),
      .i_uart_tx_vld   (tx_vld),
      .i_uart_tx_data  (tx_data),
      .o_uart_rx_data  (rx_data),
      .i_uart_rx_acp   (rx_acp),
      .i_uart_rx_pin   (rx_pin),
      .o_uart_tx_pin   (tx_pin),
      .o_uart_tx_full  (tx_full),
      .o_uart_rx_empty (rx_empty),
      .o_uart_err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---- stimulus primitives (all start and end at a falling edge) ----
   task automatic push_byte(input logic [7:0] b);
      tx_vld  = 1'b1;
      tx_data = b[3:0];
      @(negedge clk);
      tx_data = b[7:4];
      @(negedge clk);
      tx_vld  = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_line = bits[k];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx_line = 1'b1;
   endtask

   task automatic wait_rx_byte(input int budget);
      int n;
      n = 0;
      while (rx_empty && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rx_empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL rx_arrival: rx_empty=%b after %0d cycles, required 0", rx_empty, n);
      end
   endtask

   task automatic read_byte(input logic [7:0] exp);
      logic [3:0] lo, hi;
      lo = rx_data;
      tests_run++;
      if (lo !== exp[3:0]) begin
         tests_failed++;
         $display("FAIL rx_lo_nibble: got %h, required %h", lo, exp[3:0]);
      end
      rx_acp = 1'b1;
      @(negedge clk);
      rx_acp = 1'b0;
      hi = rx_data;
      tests_run++;
      if (hi !== exp[7:4]) begin
         tests_failed++;
         $display("FAIL rx_hi_nibble: got %h, required %h", hi, exp[7:4]);
      end
      rx_acp = 1'b1;
      @(negedge clk);
      rx_acp = 1'b0;
      $display("[TB] rx byte read %h%h (expected %02h)", hi, lo, exp);
   endtask

   // Watches tx_pin for one frame: every bit cell must hold for CLK_DIV cycles.
   task automatic capture_frame(input logic [7:0] b, input int budget, output int idle);
      logic [9:0] bits;
      logic [7:0] seen;
      int         bad;
      bits = {1'b1, b, 1'b0};
      seen = '0;
      bad  = 0;
      idle = 0;
      @(negedge clk);
      while (tx_pin !== 1'b0 && idle < budget) begin
         idle++;
         @(negedge clk);
      end
      tests_run++;
      if (tx_pin !== 1'b0) begin
         tests_failed++;
         $display("FAIL tx_start: pin=%b after %0d cycles, required 0", tx_pin, idle);
      end else begin
         for (int k = 0; k < 10 * CLK_DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_pin !== bits[k / CLK_DIV]) bad++;
            if (k % CLK_DIV == CLK_DIV / 2 && k >= CLK_DIV && k < 9 * CLK_DIV)
               seen[k / CLK_DIV - 1] = tx_pin;
         end
         tests_run++;
         if (bad != 0) begin
            tests_failed++;
            $display("FAIL tx_frame: got byte %02h with %0d wrong cycles, required %02h", seen, bad, b);
         end else begin
            $display("[TB] tx frame %02h after %0d idle cycles", seen, idle);
         end
      end
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run += 5;
      if (tx_pin !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx_pin: got %b, required 1", tx_pin); end
      if (tx_full !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_full: got %b, required 0", tx_full); end
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_empty: got %b, required 1", rx_empty); end
      if (rx_data !== 4'h0)  begin tests_failed++; $display("FAIL reset_rx_data: got %h, required 0", rx_data); end
      if (err !== 3'b000)    begin tests_failed++; $display("FAIL reset_err: got %b, required 000", err); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests_run += 2;
      if (tx_pin !== 1'b1)   begin tests_failed++; $display("FAIL idle_tx_pin: got %b, required 1", tx_pin); end
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL idle_rx_empty: got %b, required 1", rx_empty); end
   endtask

   task automatic test_tx_frame();
      int idle;
      push_byte(8'hA5);
      capture_frame(8'hA5, 20, idle);
      tests_run++;
      if (idle != 0) begin
         tests_failed++;
         $display("FAIL tx_latency: start bit after %0d extra cycles, required 0", idle);
      end
   endtask

   task automatic test_rx_frame();
      send_rx(8'h3C, 1'b1);
      wait_rx_byte(3 * CLK_DIV);
      read_byte(8'h3C);
      tests_run += 2;
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL rx_drained_empty: got %b, required 1", rx_empty); end
      if (rx_data !== 4'h0)  begin tests_failed++; $display("FAIL rx_drained_data: got %h, required 0", rx_data); end
      rx_acp = 1'b1;
      @(negedge clk);
      rx_acp = 1'b0;
      @(negedge clk);
      tests_run += 3;
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL acp_empty_flag: got %b, required 1", rx_empty); end
      if (rx_data !== 4'h0)  begin tests_failed++; $display("FAIL acp_empty_data: got %h, required 0", rx_data); end
      if (err !== exp_err)   begin tests_failed++; $display("FAIL acp_empty_err: got %b, required %b", err, exp_err); end
   endtask

   task automatic test_loopback_random();
      logic [7:0] b;
      loopback = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         push_byte(b);
         wait_rx_byte(14 * CLK_DIV);
         read_byte(b);
      end
      repeat (4 * CLK_DIV) @(negedge clk);
      loopback = 1'b0;
      tests_run++;
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL loopback_empty: got %b, required 1", rx_empty); end
   endtask

   task automatic test_rx_random();
      logic [7:0] q[$];
      logic [7:0] b;
      int         n;
      for (int r = 0; r < 2; r++) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            send_rx(b, 1'b1);
            repeat ($urandom_range(1, 5)) @(negedge clk);
         end
         wait_rx_byte(3 * CLK_DIV);
         while (q.size() > 0) read_byte(q.pop_front());
         tests_run++;
         if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL rx_random_empty: got %b, required 1", rx_empty); end
      end
      tests_run++;
      if (err !== exp_err) begin tests_failed++; $display("FAIL rx_random_err: got %b, required %b", err, exp_err); end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] bytes [DEPTH + 2];
      int         idle;
      int         lows;
      for (int i = 0; i < DEPTH + 2; i++) bytes[i] = 8'($urandom_range(0, 255));
      exp_err[0] = 1'b1;
      fork
         begin
            for (int i = 0; i < DEPTH + 2; i++) begin
               if (i == DEPTH + 1) begin
                  tests_run++;
                  if (tx_full !== 1'b1) begin tests_failed++; $display("FAIL tx_full_flag: got %b, required 1", tx_full); end
               end
               push_byte(bytes[i]);
            end
            tests_run++;
            if (err !== exp_err) begin tests_failed++; $display("FAIL tx_ovf_err: got %b, required %b", err, exp_err); end
         end
         begin
            for (int f = 0; f < DEPTH + 1; f++) begin
               capture_frame(bytes[f], 20, idle);
               if (f > 0) begin
                  tests_run++;
                  if (idle != 1) begin
                     tests_failed++;
                     $display("FAIL tx_back_to_back: %0d idle cycles before frame %0d, required 1", idle, f);
                  end
               end
            end
         end
      join
      lows = 0;
      for (int i = 0; i < 12 * CLK_DIV; i++) begin
         @(negedge clk);
         if (tx_pin !== 1'b1) lows++;
      end
      tests_run++;
      if (lows != 0) begin tests_failed++; $display("FAIL tx_dropped_byte: pin low %0d cycles, required 0", lows); end
   endtask

   task automatic test_rx_framing();
      send_rx(8'($urandom_range(0, 255)), 1'b0);
      repeat (6) @(negedge clk);
      exp_err[2] = 1'b1;
      tests_run += 2;
      if (err !== exp_err)   begin tests_failed++; $display("FAIL rx_frm_err: got %b, required %b", err, exp_err); end
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL rx_frm_empty: got %b, required 1", rx_empty); end
      send_rx(8'h81, 1'b1);
      wait_rx_byte(3 * CLK_DIV);
      read_byte(8'h81);
   endtask

   task automatic test_rx_overflow();
      logic [7:0] bytes [DEPTH + 1];
      for (int i = 0; i < DEPTH + 1; i++) begin
         bytes[i] = 8'($urandom_range(0, 255));
         send_rx(bytes[i], 1'b1);
         repeat (2) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      exp_err[1] = 1'b1;
      tests_run++;
      if (err !== exp_err) begin tests_failed++; $display("FAIL rx_ovf_err: got %b, required %b", err, exp_err); end
      for (int i = 0; i < DEPTH; i++) read_byte(bytes[i]);
      tests_run++;
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL rx_ovf_drained: got %b, required 1", rx_empty); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      int bad;
      int idle;
      push_byte(8'h00);
      n = 0;
      while (tx_pin !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      rx_line = 1'b0;
      repeat (2 * CLK_DIV) @(negedge clk);
      tests_run++;
      if (tx_pin !== 1'b0) begin tests_failed++; $display("FAIL mid_frame_pin: got %b, required 0", tx_pin); end
      #2 rst = 1'b1;
      #1;
      exp_err = '0;
      tests_run += 5;
      if (tx_pin !== 1'b1)   begin tests_failed++; $display("FAIL rst_async_pin: got %b, required 1", tx_pin); end
      if (tx_full !== 1'b0)  begin tests_failed++; $display("FAIL rst_mid_full: got %b, required 0", tx_full); end
      if (rx_empty !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_empty: got %b, required 1", rx_empty); end
      if (rx_data !== 4'h0)  begin tests_failed++; $display("FAIL rst_mid_data: got %h, required 0", rx_data); end
      if (err !== exp_err)   begin tests_failed++; $display("FAIL rst_mid_err: got %b, required %b", err, exp_err); end
      rx_line = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15 * CLK_DIV; i++) begin
         @(negedge clk);
         if (tx_pin !== 1'b1 || rx_empty !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL rst_quiet: %0d cycles with activity, required 0", bad); end
      push_byte(8'h5A);
      capture_frame(8'h5A, 20, idle);
      tests_run++;
      if (idle != 0) begin tests_failed++; $display("FAIL rst_resume_latency: %0d cycles, required 0", idle); end
      repeat (2) @(negedge clk);
      send_rx(8'h42, 1'b1);
      wait_rx_byte(3 * CLK_DIV);
      read_byte(8'h42);
      tests_run++;
      if (err !== exp_err) begin tests_failed++; $display("FAIL rst_resume_err: got %b, required %b", err, exp_err); end
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_rx_frame();
      test_loopback_random();
      test_rx_random();
      test_tx_overflow();
      test_rx_framing();
      test_rx_overflow();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
